// File: rtl/bps_label_assigner.sv
// Final BP stage: per pixel argmin over data cost plus four messages; eight labels
// per 64-bit word are stored to host memory. Optional feature: BPS_ASSIGNER_ENERGY_EN.
module bps_label_assigner #(
  parameter int LABELS        = 16,
  parameter int MESSAGE_WIDTH = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int FIELD_WIDTH   = 128,
  parameter int FIELD_HEIGHT  = 128,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [47:0]                     assign_base,
  input  logic                            in_push,
  input  logic [LABELS*DATA_WIDTH-1:0]    in_data,
  input  logic [LABELS*MESSAGE_WIDTH-1:0] in_h_fwd,
  input  logic [LABELS*MESSAGE_WIDTH-1:0] in_h_bwd,
  input  logic [LABELS*MESSAGE_WIDTH-1:0] in_v_fwd,
  input  logic [LABELS*MESSAGE_WIDTH-1:0] in_v_bwd,
  output logic                            in_stall,
  output logic                            mc_req_st,
  output logic [47:0]                     mc_req_vadr,
  output logic [63:0]                     mc_req_wrd_rdctl,
  input  logic                            mc_req_stall,
  output logic                            busy,
  output logic                            done
`ifdef BPS_ASSIGNER_ENERGY_EN
  ,
  output logic [31:0]                     energy
`endif
);
  localparam int N     = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int WORDS = N / 8;
  localparam int CW    = DATA_WIDTH + 3;
  localparam int PCW   = $clog2(N + 1);
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [PCW-1:0] N_L       = PCW'(N);
  localparam logic [WCW-1:0] LAST_W    = WCW'(WORDS - 1);
  localparam logic [PW-1:0]  LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [FCW-1:0] STALL_LVL = FCW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [CW-1:0] cost_sum(input logic [DATA_WIDTH-1:0]    d,
                                             input logic [MESSAGE_WIDTH-1:0] a,
                                             input logic [MESSAGE_WIDTH-1:0] b,
                                             input logic [MESSAGE_WIDTH-1:0] c,
                                             input logic [MESSAGE_WIDTH-1:0] e);
    return CW'(d) + CW'(a) + CW'(b) + CW'(c) + CW'(e);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef BPS_ASSIGNER_ENERGY_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [CW-1:0] x);
    logic [32:0] s;
    s = {1'b0, acc} + 33'(x);
    return s[32] ? '1 : s[31:0];
  endfunction
`endif

  state_t          state;
  logic [47:0]     assign_lat;
  logic [PCW-1:0]  pixel_count;
  logic [PCW-1:0]  pack_count;
  logic [WCW-1:0]  word_count;

  logic [CW-1:0]   cost_p1 [LABELS];
  logic            vld_p1;
  logic [63:0]     pack_p2;
  logic [2:0]      lane_p2;
  logic            vld_p2;

  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FCW-1:0]  fifo_count;

  logic            accept;
  logic            store_acc;
  logic            fifo_push;
  logic            fifo_pop;
  logic            drain_done;
  logic [FCW-1:0]  fifo_count_nxt;
  logic [PCW-1:0]  pixel_count_nxt;
  logic [CW-1:0]   min_cost;
  logic [7:0]      min_label;
  logic [63:0]     packed_word;

  always_comb begin
    accept          = (state == RUN) && in_push && !in_stall && (pixel_count < N_L);
    store_acc       = mc_req_st && !mc_req_stall;
    fifo_push       = vld_p2;
    fifo_pop        = (fifo_count != '0) && (!mc_req_st || !mc_req_stall);
    fifo_count_nxt  = fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
    pixel_count_nxt = pixel_count + PCW'(accept);
    drain_done      = (fifo_count == '0) && !vld_p1 && !vld_p2 && (!mc_req_st || store_acc);
  end

  // Argmin with strict compare so the lowest label index wins ties
  always_comb begin
    min_cost  = cost_p1[0];
    min_label = '0;
    for (int i = 1; i < LABELS; i++) begin
      if (cost_p1[i] < min_cost) begin
        min_cost  = cost_p1[i];
        min_label = 8'(i);
      end
    end
    packed_word = pack_p2;
    packed_word[{lane_p2, 3'b000} +: 8] = min_label;
  end

  // Stage 1: cost sums; stage 2: argmin packed into lane; stage 3: word into FIFO
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LABELS; i++) begin
        cost_p1[i] <= cost_sum(in_data[i*DATA_WIDTH +: DATA_WIDTH],
                               in_h_fwd[i*MESSAGE_WIDTH +: MESSAGE_WIDTH],
                               in_h_bwd[i*MESSAGE_WIDTH +: MESSAGE_WIDTH],
                               in_v_fwd[i*MESSAGE_WIDTH +: MESSAGE_WIDTH],
                               in_v_bwd[i*MESSAGE_WIDTH +: MESSAGE_WIDTH]);
      end
    end
    if (vld_p1) pack_p2 <= packed_word;
    if (fifo_push) fifo_mem[wr_ptr] <= pack_p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      in_stall         <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      mc_req_st        <= 1'b0;
      mc_req_vadr      <= '0;
      mc_req_wrd_rdctl <= '0;
      assign_lat       <= '0;
      pixel_count      <= '0;
      pack_count       <= '0;
      word_count       <= '0;
      lane_p2          <= '0;
      vld_p1           <= 1'b0;
      vld_p2           <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) pixel_count <= pixel_count_nxt;
      if (vld_p1) begin
        lane_p2    <= lane_p2 + 3'd1;
        pack_count <= pack_count + 1'b1;
      end
      vld_p2 <= vld_p1 && (lane_p2 == 3'd7);

      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count_nxt;

      // Output register reloads only when empty or its word is being accepted
      if (fifo_pop) begin
        mc_req_st        <= 1'b1;
        mc_req_vadr      <= assign_lat + 48'({word_count, 3'b000});
        mc_req_wrd_rdctl <= fifo_mem[rd_ptr];
        word_count       <= (word_count == LAST_W) ? '0 : word_count + 1'b1;
      end else if (store_acc) begin
        mc_req_st <= 1'b0;
      end

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            in_stall    <= 1'b0;
            assign_lat  <= assign_base;
            pixel_count <= '0;
            pack_count  <= '0;
            word_count  <= '0;
            lane_p2     <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
          end
        end
        RUN: begin
          in_stall <= (fifo_count_nxt >= STALL_LVL) || (pixel_count_nxt == N_L);
          if (vld_p1 && (pack_count == N_L - 1'b1)) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BPS_ASSIGNER_ENERGY_EN
  always_ff @(posedge clk) begin
    if (rst) energy <= '0;
    else if (state == IDLE && start) energy <= '0;
    else if (vld_p1) energy <= sat_add32(energy, min_cost);
  end
`endif

endmodule

// File: tb/tb_bps_label_assigner.sv
// Randomized bench for bps_label_assigner: an argmin/packing model predicts the
// stored memory image; stores are collected from the port and compared per pass.
module tb_bps_label_assigner;
  localparam int L = 16, MW = 6, DW = 8, FW = 8, FH = 8;
  localparam int N = FW * FH, WORDS = N / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, in_push, in_stall, mc_req_st, mc_req_stall, busy, done;
  logic [47:0]   assign_base, mc_req_vadr;
  logic [63:0]   mc_req_wrd_rdctl;
  logic [L*DW-1:0] in_data;
  logic [L*MW-1:0] in_h_fwd, in_h_bwd, in_v_fwd, in_v_bwd;
`ifdef BPS_ASSIGNER_ENERGY_EN
  logic [31:0]   energy;
`endif

  bps_label_assigner #(.LABELS(L), .MESSAGE_WIDTH(MW), .DATA_WIDTH(DW),
                       .FIELD_WIDTH(FW), .FIELD_HEIGHT(FH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .assign_base(assign_base),
    .in_push(in_push), .in_data(in_data), .in_h_fwd(in_h_fwd), .in_h_bwd(in_h_bwd),
    .in_v_fwd(in_v_fwd), .in_v_bwd(in_v_bwd), .in_stall(in_stall),
    .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_req_stall(mc_req_stall), .busy(busy), .done(done)
`ifdef BPS_ASSIGNER_ENERGY_EN
    , .energy(energy)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  logic [7:0] pd [N][L];
  logic [5:0] hf [N][L], hb [N][L], vf [N][L], vb [N][L];
  logic [63:0] exp_word [WORDS];
  int exp_energy;
  logic [47:0] st_addr [$];
  logic [63:0] st_data [$];
  int done_cnt, neg_cyc, last_store_cyc, done_cyc, busy_at_done;
  int cyc, stall_mode, stall_s0, stall_len;
  bit saw_stall;

  // Back-pressure generator: changes 2 time units after each rising edge
  initial begin
    mc_req_stall = 1'b0;
    cyc = 0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      case (stall_mode)
        1: mc_req_stall = (cyc >= stall_s0) && (cyc < stall_s0 + stall_len);
        2: mc_req_stall = ($urandom_range(0, 2) == 0);
        default: mc_req_stall = 1'b0;
      endcase
    end
  end

  // Store collector and hold-stability check, sampled on the falling edge
  initial begin
    logic hold_prev;
    logic [47:0] pa;
    logic [63:0] pw;
    hold_prev = 1'b0;
    pa = '0;
    pw = '0;
    neg_cyc = 0;
    forever begin
      @(negedge clk);
      neg_cyc++;
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          n_cmp++;
          if (mc_req_st !== 1'b1 || mc_req_vadr !== pa || mc_req_wrd_rdctl !== pw) begin
            n_bad++;
            $display("FAIL hold: st=%b adr=%h data=%h, required st=1 adr=%h data=%h",
                     mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, pa, pw);
          end
        end
        if (mc_req_st && !mc_req_stall) begin
          st_addr.push_back(mc_req_vadr);
          st_data.push_back(mc_req_wrd_rdctl);
          last_store_cyc = neg_cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = neg_cyc;
          busy_at_done = int'(busy);
        end
        hold_prev = mc_req_st && mc_req_stall;
        pa = mc_req_vadr;
        pw = mc_req_wrd_rdctl;
      end
    end
  end

  function automatic int cost_of(int p, int i);
    return int'(pd[p][i]) + int'(hf[p][i]) + int'(hb[p][i]) + int'(vf[p][i]) + int'(vb[p][i]);
  endfunction

  task automatic build_model();
    int best, bc;
    exp_energy = 0;
    for (int w = 0; w < WORDS; w++) exp_word[w] = '0;
    for (int p = 0; p < N; p++) begin
      best = 0;
      bc = cost_of(p, 0);
      for (int i = 1; i < L; i++) if (cost_of(p, i) < bc) begin best = i; bc = cost_of(p, i); end
      exp_word[p / 8][(p % 8) * 8 +: 8] = 8'(best);
      exp_energy += bc;
    end
  endtask

  // mode 0 random, 1 unique min at p mod 16, 2 ties, 3 all-maximum
  task automatic gen(input int mode);
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < L; i++) begin
        pd[p][i] = 8'($urandom); hf[p][i] = 6'($urandom); hb[p][i] = 6'($urandom);
        vf[p][i] = 6'($urandom); vb[p][i] = 6'($urandom);
        if (mode == 1) begin
          pd[p][i] = 8'($urandom_range(100, 255));
          hf[p][i] = 6'($urandom_range(10, 63)); hb[p][i] = 6'($urandom_range(10, 63));
          vf[p][i] = 6'($urandom_range(10, 63)); vb[p][i] = 6'($urandom_range(10, 63));
          if (i == p % L) begin pd[p][i] = 0; hf[p][i] = 0; hb[p][i] = 0; vf[p][i] = 0; vb[p][i] = 0; end
        end else if (mode == 2 && p % 3 == 0) begin
          pd[p][i] = 50; hf[p][i] = 10; hb[p][i] = 10; vf[p][i] = 10; vb[p][i] = 10;
        end else if (mode == 2 && p % 3 == 1) begin
          pd[p][i] = 200;
          if (i == 3 || i == 9) begin pd[p][i] = 5; hf[p][i] = 0; hb[p][i] = 0; vf[p][i] = 0; vb[p][i] = 0; end
        end else if (mode == 3) begin
          pd[p][i] = (i == 15) ? 8'd254 : 8'd255;
          hf[p][i] = 63; hb[p][i] = 63; vf[p][i] = 63; vb[p][i] = 63;
        end
      end
    end
    build_model();
  endtask

  task automatic drive_pixel(input int p);
    for (int i = 0; i < L; i++) begin
      in_data[i*DW +: DW] = pd[p][i];
      in_h_fwd[i*MW +: MW] = hf[p][i]; in_h_bwd[i*MW +: MW] = hb[p][i];
      in_v_fwd[i*MW +: MW] = vf[p][i]; in_v_bwd[i*MW +: MW] = vb[p][i];
    end
  endtask

  task automatic drive_garbage();
    for (int i = 0; i < L; i++) begin
      in_data[i*DW +: DW] = 8'($urandom_range(0, 3));
      in_h_fwd[i*MW +: MW] = 6'($urandom); in_h_bwd[i*MW +: MW] = 6'($urandom);
      in_v_fwd[i*MW +: MW] = 6'($urandom); in_v_bwd[i*MW +: MW] = 6'($urandom);
    end
  endtask

  task automatic run_pass(input logic [47:0] base, input int max_push, input bit start_mid);
    int p, guard;
    p = 0;
    guard = 0;
    st_addr.delete(); st_data.delete();
    done_cnt = 0; last_store_cyc = -100; done_cyc = -1; busy_at_done = -1;
    @(posedge clk); #2;
    start = 1'b1; assign_base = base;
    @(posedge clk); #2;
    start = 1'b0; assign_base = '0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_run: busy=%b required 1", busy); end
    while (p < max_push && guard < 4000) begin
      guard++;
      start = 1'b0;
      if (start_mid && p == 20) begin start = 1'b1; assign_base = 48'hBAD000; end
      if (in_stall) saw_stall = 1'b1;
      if (!in_stall && $urandom_range(0, 5) != 0) begin
        drive_pixel(p); in_push = 1'b1; p++;
      end else begin
        drive_garbage(); in_push = in_stall ? 1'b1 : 1'b0;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
    if (guard >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: pushed=%0d required %0d", p, max_push);
    end
    if (max_push == N) begin
      repeat (3) begin drive_garbage(); in_push = 1'b1; @(posedge clk); #2; end
    end
    in_push = 1'b0;
  endtask

  task automatic check_pass(input logic [47:0] base);
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin @(negedge clk); guard++; end
    n_cmp++;
    if (done_cnt == 0) begin n_bad++; $display("FAIL done_timeout: done seen %0d required 1", done_cnt); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL done_count: got %0d required 1", done_cnt); end
    n_cmp++;
    if (done_cyc != last_store_cyc + 1 || busy_at_done != 0) begin
      n_bad++;
      $display("FAIL done_timing: done@%0d busy=%0d, required @%0d busy=0", done_cyc, busy_at_done, last_store_cyc + 1);
    end
    n_cmp++;
    if (st_addr.size() != WORDS) begin n_bad++; $display("FAIL store_count: got %0d required %0d", st_addr.size(), WORDS); end
    for (int w = 0; w < WORDS && w < st_addr.size(); w++) begin
      n_cmp++;
      if (st_addr[w] !== base + 48'(8 * w) || st_data[w] !== exp_word[w]) begin
        n_bad++;
        $display("FAIL store[%0d]: adr=%h data=%h required adr=%h data=%h",
                 w, st_addr[w], st_data[w], base + 48'(8 * w), exp_word[w]);
      end
    end
`ifdef BPS_ASSIGNER_ENERGY_EN
    n_cmp++;
    if (energy !== 32'(exp_energy)) begin n_bad++; $display("FAIL energy: got %0d required %0d", energy, exp_energy); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_stall !== 1'b1 || mc_req_st !== 1'b0 || mc_req_vadr !== 48'h0 ||
        mc_req_wrd_rdctl !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: stall=%b st=%b adr=%h data=%h busy=%b done=%b required 1 0 0 0 0 0",
               in_stall, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, busy, done);
    end
`ifdef BPS_ASSIGNER_ENERGY_EN
    n_cmp++;
    if (energy !== 32'd0) begin n_bad++; $display("FAIL reset_energy: got %0d required 0", energy); end
`endif
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_unique_min();
    logic [63:0] w0, w1;
    logic [47:0] a1;
    stall_mode = 0;
    gen(1);
    run_pass(48'h1000, N, 1'b0);
    check_pass(48'h1000);
    w0 = (st_data.size() > 1) ? st_data[0] : '0;
    w1 = (st_data.size() > 1) ? st_data[1] : '0;
    a1 = (st_addr.size() > 1) ? st_addr[1] : '0;
    n_cmp++;
    if (w0 !== 64'h0706050403020100 || w1 !== 64'h0F0E0D0C0B0A0908 || a1 !== 48'h1008) begin
      n_bad++;
      $display("FAIL unique_min: w0=%h w1=%h a1=%h required 0706050403020100 0F0E0D0C0B0A0908 1008", w0, w1, a1);
    end
  endtask

  task automatic test_ties();
    logic [63:0] w0;
    stall_mode = 0;
    gen(2);
    run_pass(48'h4000, N, 1'b0);
    check_pass(48'h4000);
    w0 = (st_data.size() > 0) ? st_data[0] : '1;
    n_cmp++;
    if (w0[15:0] !== 16'h0300) begin n_bad++; $display("FAIL ties: low bytes=%h required 0300", w0[15:0]); end
  endtask

  task automatic test_max();
    logic [63:0] w0;
    stall_mode = 0;
    gen(3);
    run_pass(48'h5000, N, 1'b0);
    check_pass(48'h5000);
    w0 = (st_data.size() > 0) ? st_data[0] : '0;
    n_cmp++;
    if (w0 !== 64'h0F0F0F0F0F0F0F0F) begin n_bad++; $display("FAIL max: word=%h required 0F0F0F0F0F0F0F0F", w0); end
`ifdef BPS_ASSIGNER_ENERGY_EN
    n_cmp++;
    if (energy !== 32'd32384) begin n_bad++; $display("FAIL max_energy: got %0d required 32384", energy); end
`endif
  endtask

  task automatic test_stall();
    gen(0);
    saw_stall = 1'b0;
    stall_s0 = cyc + 5; stall_len = 60; stall_mode = 1;
    run_pass(48'h7000, N, 1'b0);
    check_pass(48'h7000);
    n_cmp++;
    if (saw_stall !== 1'b1) begin n_bad++; $display("FAIL stall_in_stall: seen=%b required 1", saw_stall); end
    stall_mode = 0;
  endtask

  task automatic test_back_to_back_random_stall();
    gen(0);
    stall_mode = 2;
    run_pass(48'h6000, N, 1'b1);
    check_pass(48'h6000);
    stall_mode = 0;
  endtask

  task automatic test_rst_mid();
    stall_mode = 0;
    gen(0);
    run_pass(48'h3000, 10, 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    st_addr.delete(); st_data.delete(); done_cnt = 0;
    @(negedge clk);
    n_cmp++;
    if (mc_req_st !== 1'b0 || busy !== 1'b0 || in_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: st=%b busy=%b stall=%b required 0 0 1", mc_req_st, busy, in_stall);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (st_addr.size() != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL rst_quiet: stores=%0d done=%0d required 0 0", st_addr.size(), done_cnt);
    end
    gen(0);
    run_pass(48'h2000, N, 1'b0);
    check_pass(48'h2000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_push = 1'b0; assign_base = '0;
    in_data = '0; in_h_fwd = '0; in_h_bwd = '0; in_v_fwd = '0; in_v_bwd = '0;
    stall_mode = 0; stall_s0 = 0; stall_len = 0; saw_stall = 1'b0;
    done_cnt = 0; last_store_cyc = 0; done_cyc = 0; busy_at_done = 0; exp_energy = 0;
    test_reset();
    test_unique_min();
    test_ties();
    test_max();
    test_stall();
    test_back_to_back_random_stall();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bps_label_assigner.md
# bps_label_assigner

Final stage after the belief-propagation sweeps. Per pixel, it adds the data cost to the four incoming messages (horizontal forward/backward, vertical forward/backward) for every label and picks the argmin label. It packs eight labels per 64-bit word and writes the words to the assignments region in host memory through the memory-controller store port. It consumes the same per-pixel data and message words that `bps` keeps in its on-chip memories.

## Interface
Parameters:
- LABELS, 16, number of labels per pixel (power of 2, ≤256)
- MESSAGE_WIDTH, 6, bits per label per message
- DATA_WIDTH, 8, bits per label data cost
- FIELD_WIDTH, 128, pixels per row
- FIELD_HEIGHT, 128, rows; N = FIELD_WIDTH*FIELD_HEIGHT, a multiple of 8
- FIFO_DEPTH, 4, output word buffer entries

Ports:
- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- assign_base  in  48  byte address of assignments region, 8-byte aligned; latched on start
- in_push  in  1  pixel inputs valid this cycle
- in_data  in  LABELS*DATA_WIDTH  data cost, label i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_h_fwd, in_h_bwd, in_v_fwd, in_v_bwd  in  LABELS*MESSAGE_WIDTH each  incoming messages, same packing
- in_stall  out  1  upstream must not push
- mc_req_st  out  1  store request valid
- mc_req_vadr  out  48  store address
- mc_req_wrd_rdctl  out  64  store data
- mc_req_stall  in  1  memory controller back-pressure
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start: latch assign_base, clear pixel_count, word_count, byte lane and FIFO, then go to RUN.
  - in_push is ignored in IDLE.
- RUN:
  - A push is accepted when in_push=1 and in_stall=0 and pixel_count<N. Each accepted push increments pixel_count.
  - Pushes while in_stall=1 or with pixel_count=N are dropped and do not count.
- Cost arithmetic:
  - cost[i] = in_data[i] + in_h_fwd[i] + in_h_bwd[i] + in_v_fwd[i] + in_v_bwd[i], all unsigned.
  - Sum width is DATA_WIDTH+3 (11 bits at defaults, maximum 507), so it never overflows.
- Argmin: lowest cost wins; on a tie, the lowest label index wins. The label is zero-extended to 8 bits.
- Packing:
  - The k-th label of a word (k = pixel index mod 8) goes to byte lane k, bits [8k+7:8k].
  - After lane 7 the word is pushed into the FIFO and the lane resets to 0.
- RUN → DRAIN when the N-th label has been packed.
- DRAIN → DONE when the FIFO is empty and no request is pending.
- DONE: assert done for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- Store address for word w = latched assign_base + 8*w; w increments per accepted store and wraps at N/8.
- FIFO full with a word arriving cannot occur. in_stall = (fifo_count ≥ FIFO_DEPTH-1) or state≠RUN or pixel_count=N.
- rst mid-pass: the next cycle is IDLE with FIFO empty. In-flight pixels and unsent words are discarded, and no store is issued after rst.

## Timing
- Reset values: in_stall=1, mc_req_st=0, mc_req_vadr=0, mc_req_wrd_rdctl=0, busy=0, done=0. All outputs are registered.
- Pipeline:
  - Cycle 0: push accepted.
  - Cycle 1: cost sums registered.
  - Cycle 2: argmin registered and packed into the lane.
  - The 8th label of a word enters the FIFO at cycle 3.
  - mc_req_st rises no earlier than cycle 4 after the accepting push.
- Store handshake:
  - A store is accepted in a cycle with mc_req_st=1 and mc_req_stall=0.
  - While mc_req_stall=1, mc_req_st, mc_req_vadr and mc_req_wrd_rdctl hold stable.
  - Back-to-back accepted stores are allowed, one per cycle.
- Throughput: one pixel per cycle with no back-pressure.
- done pulses the cycle after the last store is accepted (state DONE). busy falls in that same cycle.

## Configuration
- BPS_ASSIGNER_ENERGY_EN:
  - Defined: adds output port energy (out, 32 bits), reset and cleared on start to 0. Each accepted pixel's minimum cost is added, saturating at 2^32-1. The port is valid when done pulses and is held until the next start.
  - Undefined: no energy port and no accumulator logic. All other behaviour is identical.

## Test plan
- FIELD_WIDTH=4, FIELD_HEIGHT=4, assign_base=0x1000; 16 pushes with a unique min at label (p mod 16), mc_req_stall=0 -> two stores: 0x1000 with 0x0706050403020100, then 0x1008 with 0x0F0E0D0C0B0A0908; done pulses once.
- All costs equal for a pixel -> label 0. Costs 5,5 at labels 3 and 9 with all others larger -> label 3.
- All inputs at maximum (255 + 4*63) except label 15 = 506 -> label 15 selected, no overflow. Energy mode gives 16*506=8096 for a 4x4 field.
- mc_req_stall held high for 20 cycles during continuous pushes -> in_stall asserts once the FIFO holds 3 words, no labels are lost, addresses and data stay stable, and the final memory image matches the no-stall run.
- rst asserted after 10 pushes -> idle next cycle with mc_req_st=0 and busy=0. A new start with base 0x2000 produces a correct full pass with no stale words.
- in_push while in_stall=1, and start during RUN -> both ignored; pixel_count and store contents are unchanged.
